// File: rtl/icache_fetch_responder_if.sv
// Fetch-side and backing-memory-side signals of the instruction cache.
// The slave modport is the cache. The master modport is the fetch stage together with the backing memory.
interface icache_fetch_responder_if;
  logic [31:0] fetch_addr;
  logic        fetch_hit;
  logic [31:0] fetch_instr;
  logic        invalidate;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  fetch_addr, invalidate, mem_ack, mem_rdata,
    output fetch_hit, fetch_instr, mem_req, mem_addr
  );

  modport master (
    output fetch_addr, invalidate, mem_ack, mem_rdata,
    input  fetch_hit, fetch_instr, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_fetch_responder.sv
// icache_fetch_responder: direct-mapped, read-only instruction cache.
// A lookup is purely combinational while idle. A miss starts a line fill that
// fetches the whole line word by word over a req/ack handshake. The re-lookup
// happens once the FSM is back in IDLE.
module icache_fetch_responder #(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  icache_fetch_responder_if.slave bus
);

  localparam int OB = $clog2(WORDS_PER_LINE);
  localparam int IB = $clog2(LINES);
  localparam int TW = 32 - OB - IB - 2;
  localparam logic [OB-1:0] CNT_LAST = OB'(WORDS_PER_LINE - 1);
  localparam logic [OB-1:0] CNT_ONE  = OB'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Data and tags are never reset; the valid bits alone decide a hit.
  logic [31:0]      r_data [LINES][WORDS_PER_LINE];
  logic [TW-1:0]    r_tag  [LINES];
  logic [LINES-1:0] r_valid;

  // Line address of the fill in progress (fetch_addr[31:OB+2]).
  logic [29-OB:0]   r_base_line;
  logic [OB-1:0]    r_cnt;
  // Set when invalidate was seen during a fill, so the filled line stays invalid.
  logic             r_sticky;

  logic [OB-1:0]    w_offset;
  logic [IB-1:0]    w_index;
  logic [TW-1:0]    w_tag;
  logic [IB-1:0]    w_fill_idx;
  logic [TW-1:0]    w_fill_tag;
  logic             w_hit;
  logic             w_fill_ack;
  logic             w_fill_last;
  logic             w_unused;

  assign w_offset   = bus.fetch_addr[OB+1:2];
  assign w_index    = bus.fetch_addr[OB+IB+1:OB+2];
  assign w_tag      = bus.fetch_addr[31:OB+IB+2];
  assign w_fill_idx = r_base_line[IB-1:0];
  assign w_fill_tag = r_base_line[29-OB:IB];
  // Byte-offset bits of the fetch address play no part in the lookup.
  assign w_unused   = &{1'b0, bus.fetch_addr[1:0]};

  assign w_hit       = (r_state == ST_IDLE) && r_valid[w_index] && (r_tag[w_index] == w_tag);
  // An ack counts only while a request is outstanding.
  assign w_fill_ack  = (r_state == ST_FILL) && bus.mem_ack;
  assign w_fill_last = w_fill_ack && (r_cnt == CNT_LAST);

  assign bus.fetch_hit   = w_hit;
  assign bus.fetch_instr = w_hit ? r_data[w_index][w_offset] : 32'h0000_0000;
  assign bus.mem_req     = (r_state == ST_FILL);
  assign bus.mem_addr    = (r_state == ST_FILL) ? {r_base_line, r_cnt, 2'b00} : 32'h0000_0000;

  // Next-state logic of the fill FSM.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!w_hit && !bus.invalidate) begin
          w_state_nxt = ST_FILL;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (w_fill_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_FILL;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register plus the fill bookkeeping: base, word counter, sticky flag and valid bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_valid     <= '0;
      r_sticky    <= 1'b0;
      r_base_line <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (bus.invalidate) begin
            r_valid <= '0;
          end else if (!w_hit) begin
            r_base_line <= bus.fetch_addr[31:OB+2];
            r_cnt       <= '0;
          end else begin
            r_cnt <= r_cnt;
          end
        end
        ST_FILL: begin
          if (bus.invalidate) begin
            r_sticky <= 1'b1;
          end else begin
            r_sticky <= r_sticky;
          end
          if (w_fill_ack) begin
            r_cnt <= r_cnt + CNT_ONE;
          end else begin
            r_cnt <= r_cnt;
          end
          if (bus.invalidate) begin
            r_valid <= '0;
          end else if (w_fill_last && !r_sticky) begin
            r_valid[w_fill_idx] <= 1'b1;
          end else begin
            r_valid <= r_valid;
          end
        end
        ST_DONE: begin
          r_sticky <= 1'b0;
          if (bus.invalidate) begin
            r_valid <= '0;
          end else begin
            r_valid <= r_valid;
          end
        end
        default: begin
          r_sticky <= 1'b0;
        end
      endcase
    end
  end

  // Fill writes into the unreset data and tag arrays.
  always_ff @(posedge clk) begin
    if (w_fill_ack) begin
      r_data[w_fill_idx][r_cnt] <= bus.mem_rdata;
    end
    if (w_fill_last) begin
      r_tag[w_fill_idx] <= w_fill_tag;
    end
  end

endmodule

// File: tb/tb_icache_fetch_responder.sv
// Self-checking bench for icache_fetch_responder. The reference model keeps
// one resident line address per index. A fetch hits exactly when its line is resident.
// A miss costs WORDS_PER_LINE*ack_period+2 cycles and returns the backing-memory word.
module tb_icache_fetch_responder;
  localparam int LINES = 16;
  localparam int WPL   = 4;
  localparam int LINE_BYTES = WPL * 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  icache_fetch_responder_if bus();

  icache_fetch_responder #(.LINES(LINES), .WORDS_PER_LINE(WPL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model
  bit          m_valid [LINES];
  int unsigned m_line  [LINES];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0001 + {2'b00, a[31:2]};
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    int unsigned ln = a / LINE_BYTES;
    return m_valid[ln % LINES] && (m_line[ln % LINES] == ln);
  endfunction

  function automatic void m_fill(input logic [31:0] a);
    int unsigned ln = a / LINE_BYTES;
    m_valid[ln % LINES] = 1'b1;
    m_line[ln % LINES]  = ln;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endfunction

  // Backing memory responder
  int          ack_period = 1;
  bit          noise      = 1'b0;
  logic [31:0] ack_log [$];
  int          stall_err   = 0;
  int          hit_in_fill = 0;

  initial begin : responder
    int          wait_cnt  = 0;
    logic        prev_req  = 1'b0;
    logic        prev_ack  = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (bus.fetch_hit === 1'b1 && bus.mem_req === 1'b1) hit_in_fill++;
      if (prev_req && !prev_ack && (bus.mem_req !== 1'b1 || bus.mem_addr !== prev_addr)) stall_err++;
      prev_req  = (bus.mem_req === 1'b1);
      prev_addr = bus.mem_addr;
      if (bus.mem_req === 1'b1) begin
        wait_cnt++;
        if (wait_cnt >= ack_period) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mem_word(bus.mem_addr);
          ack_log.push_back(bus.mem_addr);
          wait_cnt = 0;
        end else begin
          bus.mem_ack   = 1'b0;
          bus.mem_rdata = $urandom;
        end
        prev_ack = bus.mem_ack;
      end else begin
        wait_cnt      = 0;
        bus.mem_ack   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.mem_rdata = $urandom;
        prev_ack      = 1'b0;
      end
    end
  end

  task automatic wait_hit(input int start, output int cyc, output logic [31:0] instr);
    cyc = start;
    forever begin
      @(negedge clk);
      if (bus.fetch_hit === 1'b1) break;
      cyc++;
      if (cyc > 500) break;
    end
    instr = bus.fetch_instr;
  endtask

  // One fetch, optionally preceded by a one-cycle invalidate pulse; returns observed and model values.
  task automatic do_fetch(input logic [31:0] a, input int p, input bit inv,
                          output int obs_cyc, output logic [31:0] obs_instr,
                          output int exp_cyc, output logic [31:0] exp_instr);
    ack_period = p;
    if (inv) begin
      @(posedge clk); #1;
      bus.invalidate = 1'b1;
      m_clear();
    end
    @(posedge clk); #1;
    bus.invalidate = 1'b0;
    ack_log.delete();
    bus.fetch_addr = a;
    exp_cyc   = m_hit(a) ? 0 : WPL * p + 2;
    exp_instr = mem_word(a);
    wait_hit(0, obs_cyc, obs_instr);
    m_fill(a);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.fetch_addr = 32'h0;
    bus.invalidate = 1'b0;
    #2 reset = 1'b0;
    m_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
    total++;
    if (bus.mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
    total++;
    if (bus.fetch_hit !== 1'b0) begin bad++; $display("FAIL reset_hit: got %b want 0", bus.fetch_hit); end
    total++;
    if (bus.fetch_instr !== 32'h0) begin bad++; $display("FAIL reset_instr: got %h want 0", bus.fetch_instr); end
    total++;
  endtask

  task automatic test_cold_miss();
    int cyc, ec; logic [31:0] ins, ei;
    ack_period = 1;
    @(posedge clk); #1;
    ack_log.delete();
    reset = 1'b1;
    wait_hit(0, cyc, ins);
    m_fill(32'h0);
    if (cyc != 6) begin bad++; $display("FAIL cold_latency: got %0d want 6", cyc); end
    total++;
    if (ins !== 32'h1000_0001) begin bad++; $display("FAIL cold_instr: got %h want 10000001", ins); end
    total++;
    if (ack_log.size() != 4) begin bad++; $display("FAIL cold_nreq: got %0d want 4", ack_log.size()); end
    total++;
    for (int i = 0; i < ack_log.size(); i++) begin
      if (ack_log[i] !== 32'(4 * i)) begin bad++; $display("FAIL cold_addr%0d: got %h want %h", i, ack_log[i], 32'(4 * i)); end
      total++;
    end
    do_fetch(32'h8, 1, 1'b0, cyc, ins, ec, ei);
    if (cyc != 0) begin bad++; $display("FAIL follow_hit: got %0d cycles want 0", cyc); end
    total++;
    if (ins !== 32'h1000_0003) begin bad++; $display("FAIL follow_instr: got %h want 10000003", ins); end
    total++;
    if (ack_log.size() != 0) begin bad++; $display("FAIL follow_noreq: got %0d reqs want 0", ack_log.size()); end
    total++;
  endtask

  task automatic test_stall();
    int cyc, ec; logic [31:0] ins, ei;
    do_fetch(32'h10, 3, 1'b0, cyc, ins, ec, ei);
    if (cyc != ec || cyc != 14) begin bad++; $display("FAIL stall_latency: got %0d want %0d", cyc, ec); end
    total++;
    if (ins !== ei) begin bad++; $display("FAIL stall_instr: got %h want %h", ins, ei); end
    total++;
    if (stall_err != 0) begin bad++; $display("FAIL stall_hold: got %0d unstable cycles want 0", stall_err); end
    total++;
    if (ack_log.size() != 4) begin bad++; $display("FAIL stall_nreq: got %0d want 4", ack_log.size()); end
    total++;
  endtask

  task automatic test_conflict();
    int cyc, ec; logic [31:0] ins, ei;
    do_fetch(32'h100, 1, 1'b0, cyc, ins, ec, ei);
    if (cyc != 6 || cyc != ec) begin bad++; $display("FAIL evict_latency: got %0d want %0d", cyc, ec); end
    total++;
    if (ins !== 32'h1000_0041) begin bad++; $display("FAIL evict_instr: got %h want 10000041", ins); end
    total++;
    do_fetch(32'h0, 1, 1'b0, cyc, ins, ec, ei);
    if (cyc != 6 || cyc != ec) begin bad++; $display("FAIL reevict_latency: got %0d want %0d", cyc, ec); end
    total++;
    if (ins !== 32'h1000_0001) begin bad++; $display("FAIL reevict_instr: got %h want 10000001", ins); end
    total++;
  endtask

  task automatic test_invalidate();
    int cyc, ec; logic [31:0] ins, ei;
    do_fetch(32'h10, 1, 1'b0, cyc, ins, ec, ei);
    if (cyc != ec) begin bad++; $display("FAIL inv_pre: got %0d want %0d", cyc, ec); end
    total++;
    do_fetch(32'h0, 1, 1'b1, cyc, ins, ec, ei);
    if (cyc != 6 || cyc != ec) begin bad++; $display("FAIL inv_line0: got %0d want 6", cyc); end
    total++;
    if (ack_log.size() != 4) begin bad++; $display("FAIL inv_line0_nreq: got %0d want 4", ack_log.size()); end
    total++;
    do_fetch(32'h10, 1, 1'b0, cyc, ins, ec, ei);
    if (cyc != 6 || cyc != ec) begin bad++; $display("FAIL inv_line1: got %0d want 6", cyc); end
    total++;
    if (ins !== 32'h1000_0005) begin bad++; $display("FAIL inv_line1_instr: got %h want 10000005", ins); end
    total++;
  endtask

  task automatic test_invalidate_during_fill();
    int cyc; logic [31:0] ins;
    ack_period = 1;
    @(posedge clk); #1;
    ack_log.delete();
    bus.fetch_addr = 32'h30;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.invalidate = 1'b1;
    @(posedge clk); #1;
    bus.invalidate = 1'b0;
    m_clear();
    wait_hit(3, cyc, ins);
    m_fill(32'h30);
    if (cyc != 12) begin bad++; $display("FAIL invfill_latency: got %0d want 12", cyc); end
    total++;
    if (ins !== mem_word(32'h30)) begin bad++; $display("FAIL invfill_instr: got %h want %h", ins, mem_word(32'h30)); end
    total++;
    if (ack_log.size() != 8) begin bad++; $display("FAIL invfill_nreq: got %0d want 8", ack_log.size()); end
    total++;
    if (ack_log.size() == 8 && ack_log[4] !== 32'h30) begin bad++; $display("FAIL invfill_refill_base: got %h want 30", ack_log[4]); end
    total++;
  endtask

  task automatic test_reset_mid_fill();
    int cyc; logic [31:0] ins;
    ack_period = 1;
    @(posedge clk); #1;
    ack_log.delete();
    bus.fetch_addr = 32'h50;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_clear();
    #1;
    if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL rstfill_req: got %b want 0", bus.mem_req); end
    total++;
    if (bus.fetch_hit !== 1'b0) begin bad++; $display("FAIL rstfill_hit: got %b want 0", bus.fetch_hit); end
    total++;
    if (ack_log.size() != 2) begin bad++; $display("FAIL rstfill_acks: got %0d want 2", ack_log.size()); end
    total++;
    repeat (2) @(posedge clk);
    #1;
    ack_log.delete();
    reset = 1'b1;
    wait_hit(0, cyc, ins);
    m_fill(32'h50);
    if (cyc != 6) begin bad++; $display("FAIL rstfill_latency: got %0d want 6", cyc); end
    total++;
    if (ack_log.size() == 0 || ack_log[0] !== 32'h50) begin bad++; $display("FAIL rstfill_base: got %0d reqs, want first at 50", ack_log.size()); end
    total++;
    if (ins !== mem_word(32'h50)) begin bad++; $display("FAIL rstfill_instr: got %h want %h", ins, mem_word(32'h50)); end
    total++;
  endtask

  task automatic test_addr_change();
    int cyc, ec; logic [31:0] ins, ei;
    ack_period = 1;
    @(posedge clk); #1;
    ack_log.delete();
    bus.fetch_addr = 32'h20;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.fetch_addr = 32'h40;
    wait_hit(2, cyc, ins);
    m_fill(32'h20);
    m_fill(32'h40);
    if (cyc != 12) begin bad++; $display("FAIL chg_latency: got %0d want 12", cyc); end
    total++;
    if (ins !== mem_word(32'h40)) begin bad++; $display("FAIL chg_instr: got %h want %h", ins, mem_word(32'h40)); end
    total++;
    if (ack_log.size() != 8 || ack_log[3] !== 32'h2C || ack_log[4] !== 32'h40) begin
      bad++; $display("FAIL chg_seq: got %0d reqs, want 20..2C then 40..4C", ack_log.size());
    end
    total++;
    if (hit_in_fill != 0) begin bad++; $display("FAIL chg_hit_in_fill: got %0d want 0", hit_in_fill); end
    total++;
    do_fetch(32'h24, 1, 1'b0, cyc, ins, ec, ei);
    if (cyc != 0 || cyc != ec) begin bad++; $display("FAIL chg_line20_hit: got %0d want 0", cyc); end
    total++;
    if (ins !== ei) begin bad++; $display("FAIL chg_line20_instr: got %h want %h", ins, ei); end
    total++;
  endtask

  task automatic test_random();
    int cyc, ec; logic [31:0] ins, ei, a;
    noise = 1'b1;
    for (int n = 0; n < 40; n++) begin
      a = 32'($urandom_range(0, 1023)) & 32'hFFFF_FFFC;
      do_fetch(a, $urandom_range(1, 3), ($urandom_range(0, 7) == 0), cyc, ins, ec, ei);
      if (cyc != ec) begin bad++; $display("FAIL rnd_latency[%0d] addr %h: got %0d want %0d", n, a, cyc, ec); end
      total++;
      if (ins !== ei) begin bad++; $display("FAIL rnd_instr[%0d] addr %h: got %h want %h", n, a, ins, ei); end
      total++;
      if (ack_log.size() != ((ec == 0) ? 0 : WPL) ||
          (ec != 0 && ack_log.size() > 0 && ack_log[0] !== (a & 32'hFFFF_FFF0))) begin
        bad++; $display("FAIL rnd_reqs[%0d] addr %h: got %0d reqs", n, a, ack_log.size());
      end
      total++;
    end
    noise = 1'b0;
    if (stall_err != 0) begin bad++; $display("FAIL rnd_hold: got %0d unstable cycles want 0", stall_err); end
    total++;
    if (hit_in_fill != 0) begin bad++; $display("FAIL rnd_hit_in_fill: got %0d want 0", hit_in_fill); end
    total++;
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_stall();
    test_conflict();
    test_invalidate();
    test_invalidate_during_fill();
    test_reset_mid_fill();
    test_addr_change();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad + 1);
    $fatal(1, "watchdog");
  end
endmodule
